// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage pipeline.
//
// Purpose:
//   Consumes the ID/EX bundle, decodes the EX control field and funct bits,
//   computes the ALU result and the destination register, and registers the
//   outcome into the EX/MEM bundle. An iterative unsigned multiply/divide
//   unit (one bit per cycle) owns the HI/LO registers and holds the upstream
//   stages frozen through ex_stall while it works.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   ID_EX_RsData      operand A
//   ID_EX_RtData      operand B (register form) and store data
//   ID_EX_RdAddr      destination register when RegDst=1
//   ID_EX_RtAddr      destination register when RegDst=0
//   ID_EX_SignExtend  immediate, bits [5:0] double as funct
//   ID_EX_M           {MemRead, MemWrite}
//   ID_EX_EX          {RegDst, ALUOp[1:0], ALUSrc}
//   ID_EX_WB          {RegWrite, MemtoReg}
//   ex_stall          combinational freeze of PC, IF/ID and ID/EX
//   EX_MEM_*          registered result bundle for the MEM stage

module ex_stage #(
  parameter int ENABLE_MULDIV = 1,
  parameter int MD_ITER       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ID_EX_RsData,
  input  logic [31:0] ID_EX_RtData,
  input  logic [4:0]  ID_EX_RdAddr,
  input  logic [4:0]  ID_EX_RtAddr,
  input  logic [31:0] ID_EX_SignExtend,
  input  logic [1:0]  ID_EX_M,
  input  logic [3:0]  ID_EX_EX,
  input  logic [1:0]  ID_EX_WB,
  output logic        ex_stall,
  output logic [31:0] EX_MEM_AluResult,
  output logic [31:0] EX_MEM_WriteData,
  output logic [4:0]  EX_MEM_WriteReg,
  output logic        EX_MEM_Zero,
  output logic [1:0]  EX_MEM_M,
  output logic [1:0]  EX_MEM_WB
);

  localparam int CW = $clog2(MD_ITER);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdState_e;

  mdState_e        r_state;
  mdState_e        w_nextState;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_operand;
  logic [31:0]     r_hiAcc;
  logic [31:0]     r_loAcc;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  logic            w_regDst;
  logic [1:0]      w_aluOp;
  logic            w_aluSrc;
  logic [5:0]      w_funct;
  logic [31:0]     w_opA;
  logic [31:0]     w_opB;
  logic [4:0]      w_writeReg;
  logic [31:0]     w_aluResult;
  logic            w_isMulDiv;
  logic            w_start;
  logic            w_lastIter;
  logic            w_bubble;
  logic [32:0]     w_mulSum;
  logic [63:0]     w_mulNext;
  logic [32:0]     w_divShift;
  logic [32:0]     w_divTrial;
  logic [31:0]     w_divRem;
  logic [31:0]     w_divQuo;

  assign w_regDst   = ID_EX_EX[3];
  assign w_aluOp    = ID_EX_EX[2:1];
  assign w_aluSrc   = ID_EX_EX[0];
  assign w_funct    = ID_EX_SignExtend[5:0];
  assign w_opA      = ID_EX_RsData;
  assign w_opB      = w_aluSrc ? ID_EX_SignExtend : ID_EX_RtData;
  assign w_writeReg = w_regDst ? ID_EX_RdAddr : ID_EX_RtAddr;

  assign w_isMulDiv = (w_aluOp == 2'b10) && ((w_funct == FN_MULTU) || (w_funct == FN_DIVU));
  assign w_start    = (ENABLE_MULDIV != 0) && w_isMulDiv && (r_state == IDLE);
  assign w_lastIter = (r_count == CW'(MD_ITER - 1));

  // A mul/div instruction never writes a GPR or touches memory, so it leaves
  // as a bubble; the same holds for every cycle the pipeline is frozen.
  assign w_bubble   = ex_stall || w_isMulDiv;

  // Shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole {carry, hi, lo} right by one. The multiplier sits in
  // lo and is consumed from its LSB as product bits are shifted in on top.
  assign w_mulSum   = {1'b0, r_hiAcc} + (r_loAcc[0] ? {1'b0, r_operand} : 33'd0);
  assign w_mulNext  = {w_mulSum, r_loAcc[31:1]};

  // Restoring division step: bring the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not go negative. A zero
  // divisor always "succeeds", which naturally yields all-ones quotient and
  // the dividend as remainder.
  assign w_divShift = {r_hiAcc, r_loAcc[31]};
  assign w_divTrial = w_divShift - {1'b0, r_operand};
  assign w_divRem   = w_divTrial[32] ? w_divShift[31:0] : w_divTrial[31:0];
  assign w_divQuo   = {r_loAcc[30:0], ~w_divTrial[32]};

  // Main ALU: ALUOp picks the fixed operations, R-type falls through to the
  // funct decode. MFHI/MFLO read the architectural HI/LO directly.
  always_comb begin
    w_aluResult = '0;
    case (w_aluOp)
      2'b00: w_aluResult = w_opA + w_opB;
      2'b01: w_aluResult = w_opA - w_opB;
      2'b11: w_aluResult = w_opA | {16'b0, ID_EX_SignExtend[15:0]};
      default: begin
        case (w_funct)
          6'h20, 6'h21: w_aluResult = w_opA + w_opB;
          6'h22, 6'h23: w_aluResult = w_opA - w_opB;
          6'h24:        w_aluResult = w_opA & w_opB;
          6'h25:        w_aluResult = w_opA | w_opB;
          6'h26:        w_aluResult = w_opA ^ w_opB;
          6'h27:        w_aluResult = ~(w_opA | w_opB);
          6'h2A:        w_aluResult = {31'b0, $signed(w_opA) < $signed(w_opB)};
          6'h2B:        w_aluResult = {31'b0, w_opA < w_opB};
          FN_MFHI:      w_aluResult = r_hi;
          FN_MFLO:      w_aluResult = r_lo;
          default:      w_aluResult = '0;
        endcase
      end
    endcase
  end

  // Mul/div FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Mul/div FSM next-state: DONE exists so that the cycle after the last
  // iteration is unstalled, letting upstream advance exactly once.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = (w_funct == FN_MULTU) ? MUL : DIV;
      MUL,
      DIV:     if (w_lastIter) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Mul/div FSM output: stall starts combinationally in the issue cycle so
  // the instruction stays put in ID/EX; reset forces it low.
  always_comb begin
    ex_stall = 1'b0;
    case (r_state)
      IDLE:    ex_stall = w_start;
      MUL,
      DIV:     ex_stall = 1'b1;
      default: ex_stall = 1'b0;
    endcase
    if (!rst_n) ex_stall = 1'b0;
  end

  // Mul/div datapath: operands are captured at issue so later ID/EX changes
  // cannot disturb the iteration; HI/LO change only on the final iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_operand <= '0;
      r_hiAcc   <= '0;
      r_loAcc   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_count <= '0;
            r_hiAcc <= '0;
            if (w_funct == FN_MULTU) begin
              r_operand <= w_opA;
              r_loAcc   <= w_opB;
            end else begin
              r_operand <= w_opB;
              r_loAcc   <= w_opA;
            end
          end
        end
        MUL: begin
          r_count <= r_count + 1'b1;
          r_hiAcc <= w_mulNext[63:32];
          r_loAcc <= w_mulNext[31:0];
          if (w_lastIter) begin
            r_hi <= w_mulNext[63:32];
            r_lo <= w_mulNext[31:0];
          end
        end
        DIV: begin
          r_count <= r_count + 1'b1;
          r_hiAcc <= w_divRem;
          r_loAcc <= w_divQuo;
          if (w_lastIter) begin
            r_hi <= w_divRem;
            r_lo <= w_divQuo;
          end
        end
        default: ;
      endcase
    end
  end

  // EX/MEM pipeline register: a bubble clears the whole bundle so nothing
  // downstream can act on it.
  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      EX_MEM_AluResult <= '0;
      EX_MEM_WriteData <= '0;
      EX_MEM_WriteReg  <= '0;
      EX_MEM_Zero      <= 1'b0;
      EX_MEM_M         <= '0;
      EX_MEM_WB        <= '0;
    end else begin
      EX_MEM_AluResult <= w_aluResult;
      EX_MEM_WriteData <= ID_EX_RtData;
      EX_MEM_WriteReg  <= w_writeReg;
      EX_MEM_Zero      <= (w_aluResult == 32'd0);
      EX_MEM_M         <= ID_EX_M;
      EX_MEM_WB        <= ID_EX_WB;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- scoreboard testbench for ex_stage.
//
// Purpose:
//   Issues directed instructions, pushing the hand-computed EX/MEM bundle and
//   ex_stall value for each cycle into a queue; an independent monitor pops
//   entries as their cycle arrives and compares against the DUT.
//
// Ports: none (top-level bench).

module tb_ex_stage;

  localparam int MD_ITER = 32;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rta;
    logic [1:0]  m;
    logic [3:0]  ex;
    logic [1:0]  wb;
  } instrT;

  typedef struct {
    logic [31:0] res;
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        zero;
    logic [1:0]  m;
    logic [1:0]  wb;
  } outT;

  typedef struct {
    int    cyc;
    bit    isStall;
    logic  stallV;
    outT   o;
    string name;
  } sbEntryT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ID_EX_RsData = '0;
  logic [31:0] ID_EX_RtData = '0;
  logic [4:0]  ID_EX_RdAddr = '0;
  logic [4:0]  ID_EX_RtAddr = '0;
  logic [31:0] ID_EX_SignExtend = '0;
  logic [1:0]  ID_EX_M = '0;
  logic [3:0]  ID_EX_EX = '0;
  logic [1:0]  ID_EX_WB = '0;
  logic        ex_stall;
  logic [31:0] EX_MEM_AluResult;
  logic [31:0] EX_MEM_WriteData;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_MEM_Zero;
  logic [1:0]  EX_MEM_M;
  logic [1:0]  EX_MEM_WB;

  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  sbEntryT sbQ[$];
  sbEntryT monE;
  outT     zeroOut;

  ex_stage #(.ENABLE_MULDIV(1), .MD_ITER(MD_ITER)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_RsData     (ID_EX_RsData),
    .ID_EX_RtData     (ID_EX_RtData),
    .ID_EX_RdAddr     (ID_EX_RdAddr),
    .ID_EX_RtAddr     (ID_EX_RtAddr),
    .ID_EX_SignExtend (ID_EX_SignExtend),
    .ID_EX_M          (ID_EX_M),
    .ID_EX_EX         (ID_EX_EX),
    .ID_EX_WB         (ID_EX_WB),
    .ex_stall         (ex_stall),
    .EX_MEM_AluResult (EX_MEM_AluResult),
    .EX_MEM_WriteData (EX_MEM_WriteData),
    .EX_MEM_WriteReg  (EX_MEM_WriteReg),
    .EX_MEM_Zero      (EX_MEM_Zero),
    .EX_MEM_M         (EX_MEM_M),
    .EX_MEM_WB        (EX_MEM_WB)
  );

  // Free-running clock with a cycle counter that tags scoreboard entries.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic instrT mkInstr(logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                                    logic [4:0] rd, logic [4:0] rta, logic [1:0] m,
                                    logic [3:0] ex, logic [1:0] wb);
    instrT t;
    t.rs = rs; t.rt = rt; t.imm = imm; t.rd = rd; t.rta = rta;
    t.m = m; t.ex = ex; t.wb = wb;
    return t;
  endfunction

  function automatic outT mkOut(logic [31:0] res, logic [31:0] data, logic [4:0] wreg,
                                logic zero, logic [1:0] m, logic [1:0] wb);
    outT o;
    o.res = res; o.data = data; o.wreg = wreg; o.zero = zero; o.m = m; o.wb = wb;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instrT t);
    ID_EX_RsData     = t.rs;
    ID_EX_RtData     = t.rt;
    ID_EX_SignExtend = t.imm;
    ID_EX_RdAddr     = t.rd;
    ID_EX_RtAddr     = t.rta;
    ID_EX_M          = t.m;
    ID_EX_EX         = t.ex;
    ID_EX_WB         = t.wb;
  endtask

  // The stall expectation belongs to the current cycle; the EX/MEM
  // expectation appears after the next rising edge.
  task automatic pushCycle(input string n, input logic stallV, input outT o);
    sbEntryT e;
    e.cyc = cyc; e.isStall = 1'b1; e.stallV = stallV; e.o = zeroOut; e.name = {n, "_stall"};
    sbQ.push_back(e);
    e.cyc = cyc + 1; e.isStall = 1'b0; e.stallV = 1'b0; e.o = o; e.name = n;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input string n, input instrT t, input outT o);
    rst_n = 1'b1;
    drive(t);
    pushCycle(n, 1'b0, o);
    step();
  endtask

  task automatic applyReset(input string n, input instrT t, input int cycles);
    rst_n = 1'b0;
    drive(t);
    for (int i = 0; i < cycles; i++) begin
      pushCycle(n, 1'b0, zeroOut);
      step();
    end
  endtask

  // Holds a MULTU/DIVU in ID/EX: stalled for MD_ITER+1 cycles, then one
  // unstalled DONE cycle; every EX/MEM output meanwhile is a bubble.
  // A non-negative abortAt stops after that many cycles instead.
  task automatic applyMulDiv(input string n, input instrT t, input int abortAt);
    int total;
    total = (abortAt >= 0) ? abortAt : MD_ITER + 2;
    rst_n = 1'b1;
    drive(t);
    for (int i = 0; i < total; i++) begin
      pushCycle(n, (i <= MD_ITER) ? 1'b1 : 1'b0, zeroOut);
      step();
    end
  endtask

  task automatic checkOutput(input sbEntryT e);
    checks++;
    if (e.isStall) begin
      if (ex_stall !== e.stallV) begin
        errors++;
        $display("[TB] FAIL %s cyc=%0d ex_stall got=%b expected=%b", e.name, e.cyc, ex_stall, e.stallV);
      end
    end else if (EX_MEM_AluResult !== e.o.res || EX_MEM_WriteData !== e.o.data ||
                 EX_MEM_WriteReg !== e.o.wreg || EX_MEM_Zero !== e.o.zero ||
                 EX_MEM_M !== e.o.m || EX_MEM_WB !== e.o.wb) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got res=%h data=%h reg=%0d z=%b m=%b wb=%b expected res=%h data=%h reg=%0d z=%b m=%b wb=%b",
               e.name, e.cyc, EX_MEM_AluResult, EX_MEM_WriteData, EX_MEM_WriteReg, EX_MEM_Zero,
               EX_MEM_M, EX_MEM_WB, e.o.res, e.o.data, e.o.wreg, e.o.zero, e.o.m, e.o.wb);
    end
  endtask

  // Monitor: away from the rising edge, retire every entry due this cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      monE = sbQ.pop_front();
      checkOutput(monE);
    end
  end

  // Directed stimulus with hand-computed results.
  initial begin
    instrT mfhi, mflo;
    zeroOut = mkOut(32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 2'b00);
    mfhi = mkInstr(32'h0, 32'h0, 32'h10, 5'd3, 5'd0, 2'b00, 4'b1100, 2'b10);
    mflo = mkInstr(32'h0, 32'h0, 32'h12, 5'd4, 5'd0, 2'b00, 4'b1100, 2'b10);
    step();

    applyReset("reset", mkInstr(32'hFFFFFFFF, 32'h2, 32'h19, 5'd7, 5'd9, 2'b11, 4'b1100, 2'b11), 2);
    applyStimulus("mfhi_after_reset", mfhi, mkOut(32'h0, 32'h0, 5'd3, 1'b1, 2'b00, 2'b10));

    applyStimulus("add", mkInstr(32'h7FFFFFFF, 32'h1, 32'h20, 5'd5, 5'd9, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'h80000000, 32'h1, 5'd5, 1'b0, 2'b00, 2'b10));
    applyStimulus("lw", mkInstr(32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd1, 5'd8, 2'b10, 4'b0001, 2'b11),
                  mkOut(32'h0FFC, 32'hDEAD, 5'd8, 1'b0, 2'b10, 2'b11));
    applyStimulus("beq", mkInstr(32'h55, 32'h55, 32'h4, 5'd1, 5'd2, 2'b00, 4'b0010, 2'b00),
                  mkOut(32'h0, 32'h55, 5'd2, 1'b1, 2'b00, 2'b00));
    applyStimulus("sub", mkInstr(32'h5, 32'h7, 32'h22, 5'd6, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'hFFFFFFFE, 32'h7, 5'd6, 1'b0, 2'b00, 2'b10));
    applyStimulus("and", mkInstr(32'hF0F0F0F0, 32'hFF00FF00, 32'h24, 5'd7, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'hF000F000, 32'hFF00FF00, 5'd7, 1'b0, 2'b00, 2'b10));
    applyStimulus("or", mkInstr(32'hF0F0F0F0, 32'hFF00FF00, 32'h25, 5'd7, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'hFFF0FFF0, 32'hFF00FF00, 5'd7, 1'b0, 2'b00, 2'b10));
    applyStimulus("xor", mkInstr(32'hF0F0F0F0, 32'hFF00FF00, 32'h26, 5'd7, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'h0FF00FF0, 32'hFF00FF00, 5'd7, 1'b0, 2'b00, 2'b10));
    applyStimulus("nor", mkInstr(32'hF0F0F0F0, 32'hFF00FF00, 32'h27, 5'd7, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'h000F000F, 32'hFF00FF00, 5'd7, 1'b0, 2'b00, 2'b10));
    applyStimulus("slt", mkInstr(32'hFFFFFFFF, 32'h1, 32'h2A, 5'd10, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'h1, 32'h1, 5'd10, 1'b0, 2'b00, 2'b10));
    applyStimulus("sltu", mkInstr(32'hFFFFFFFF, 32'h1, 32'h2B, 5'd11, 5'd1, 2'b00, 4'b1100, 2'b10),
                  mkOut(32'h0, 32'h1, 5'd11, 1'b1, 2'b00, 2'b10));
    applyStimulus("ori", mkInstr(32'hF0000000, 32'h3, 32'hFFFF1234, 5'd1, 5'd12, 2'b00, 4'b0111, 2'b10),
                  mkOut(32'hF0001234, 32'h3, 5'd12, 1'b0, 2'b00, 2'b10));
    applyStimulus("bad_funct", mkInstr(32'h12345678, 32'h9, 32'h3F, 5'd13, 5'd1, 2'b01, 4'b1100, 2'b10),
                  mkOut(32'h0, 32'h9, 5'd13, 1'b1, 2'b01, 2'b10));

    applyMulDiv("multu", mkInstr(32'hFFFFFFFF, 32'h2, 32'h19, 5'd14, 5'd1, 2'b00, 4'b1100, 2'b10), -1);
    applyStimulus("mfhi_mul", mfhi, mkOut(32'h1, 32'h0, 5'd3, 1'b0, 2'b00, 2'b10));
    applyStimulus("mflo_mul", mflo, mkOut(32'hFFFFFFFE, 32'h0, 5'd4, 1'b0, 2'b00, 2'b10));

    applyMulDiv("divu_100_7", mkInstr(32'd100, 32'd7, 32'h1B, 5'd15, 5'd1, 2'b00, 4'b1100, 2'b10), -1);
    applyStimulus("mflo_div", mflo, mkOut(32'd14, 32'h0, 5'd4, 1'b0, 2'b00, 2'b10));
    applyStimulus("mfhi_div", mfhi, mkOut(32'd2, 32'h0, 5'd3, 1'b0, 2'b00, 2'b10));

    applyMulDiv("divu_100_0", mkInstr(32'd100, 32'd0, 32'h1B, 5'd15, 5'd1, 2'b00, 4'b1100, 2'b10), -1);
    applyStimulus("mflo_div0", mflo, mkOut(32'hFFFFFFFF, 32'h0, 5'd4, 1'b0, 2'b00, 2'b10));
    applyStimulus("mfhi_div0", mfhi, mkOut(32'd100, 32'h0, 5'd3, 1'b0, 2'b00, 2'b10));

    // Issue cycle plus iterations 0..9, then reset lands at iteration 10.
    applyMulDiv("divu_abort", mkInstr(32'd50, 32'd7, 32'h1B, 5'd15, 5'd1, 2'b00, 4'b1100, 2'b10), 11);
    applyReset("abort_reset", mkInstr(32'd50, 32'd7, 32'h1B, 5'd15, 5'd1, 2'b00, 4'b1100, 2'b10), 1);
    applyStimulus("mfhi_abort", mfhi, mkOut(32'h0, 32'h0, 5'd3, 1'b1, 2'b00, 2'b10));
    applyStimulus("mflo_abort", mflo, mkOut(32'h0, 32'h0, 5'd4, 1'b1, 2'b00, 2'b10));

    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; it is the consumer of the ID/EX pipeline-register bundle.
- Decodes the EX control field and the funct bits, then computes the ALU result and selects the write register.
- Contains an iterative unsigned multiply/divide unit with HI/LO registers. While that unit is busy, the block stalls the upstream stages.
- Results go out through the registered EX/MEM bundle, which the MEM stage consumes.

Parameters:
- ENABLE_MULDIV, 1: 0 makes MULTU/DIVU retire as a bubble in one cycle, with no stall and no HI/LO update.
- MD_ITER, 32: number of iteration cycles per multiply/divide. Must equal the data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- ID_EX_RsData  in  32  operand A.
- ID_EX_RtData  in  32  operand B (register) and store data.
- ID_EX_RdAddr  in  5  destination register when RegDst=1.
- ID_EX_RtAddr  in  5  destination register when RegDst=0.
- ID_EX_SignExtend  in  32  immediate; bits [5:0] are the funct.
- ID_EX_M  in  2  {MemRead, MemWrite}, passed through.
- ID_EX_EX  in  4  {RegDst, ALUOp[1:0], ALUSrc}.
- ID_EX_WB  in  2  {RegWrite, MemtoReg}, passed through.
- ex_stall  out  1  combinational; 1 freezes the PC, IF/ID and ID/EX registers.
- EX_MEM_AluResult  out  32  registered result.
- EX_MEM_WriteData  out  32  registered RtData.
- EX_MEM_WriteReg  out  5  registered destination register.
- EX_MEM_Zero  out  1  registered flag: AluResult==0.
- EX_MEM_M  out  2  registered M field.
- EX_MEM_WB  out  2  registered WB field.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset: every EX_MEM_* output = 0; HI = LO = 0; FSM in IDLE; iteration counter = 0; ex_stall = 0. Reset asserted mid-operation aborts the operation with no HI/LO update.
- Operand B: ALUSrc ? SignExtend : RtData.
- Write register: RegDst ? RdAddr : RtAddr.
- ALUOp 00: A+B, wrapping, used by lw/sw.
- ALUOp 01: A−B, used by beq.
- ALUOp 11: A | {16'b0, SignExtend[15:0]}.
- ALUOp 10: R-type, selected by funct:
  - 0x20/0x21: add.
  - 0x22/0x23: sub.
  - 0x24: and. 0x25: or. 0x26: xor. 0x27: nor.
  - 0x2A: signed slt, result 1 or 0.
  - 0x2B: unsigned sltu.
  - 0x10: result = HI (MFHI). 0x12: result = LO (MFLO).
  - 0x19: MULTU. 0x1B: DIVU.
  - Any other funct: result 0, control fields passed unchanged.
- Latency: 1 cycle for all non-mul/div instructions. While ex_stall=0, the EX_MEM_* registers capture the computed values on every edge.
- Multiply/divide FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: if ALUOp=10, funct is 0x19 or 0x1B, and ENABLE_MULDIV=1, then ex_stall=1 combinationally. The FSM latches the operands, clears the counter, and moves to MUL or DIV.
  - MUL: shift-add, one bit per cycle. ex_stall=1.
  - DIV: restoring division, one bit per cycle. ex_stall=1.
  - After MD_ITER cycles in MUL or DIV: MUL writes HI:LO = 64-bit product; DIV writes LO = quotient, HI = remainder. The FSM then moves to DONE.
  - DONE: ex_stall=0. On the next edge the FSM moves to IDLE, and upstream advances the next instruction into ID/EX.
  - Total ex_stall = MD_ITER+1 cycles per MULTU/DIVU.
- Bubbles: whenever ex_stall=1, or the current instruction is MULTU/DIVU (including its DONE cycle), EX_MEM_M and EX_MEM_WB are loaded with 0. The other EX_MEM outputs are don't-care, but bench compares use 0.
- HI/LO updates occur only on MUL/DIV completion, never from a GPR write.
- Divide by zero: takes the normal MD_ITER cycles; result LO = 0xFFFFFFFF, HI = dividend.
- MFHI/MFLO immediately after DONE: sees the updated HI/LO. No extra stall.
- Inputs are assumed stable while ex_stall=1, because upstream is frozen.
- ID/EX field changes during MUL/DIV are ignored; the operands were latched at start.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with arbitrary inputs → all EX_MEM_* = 0, ex_stall=0. After release, an MFHI instruction returns 0.
- Add: ALUOp=10, funct=0x20, Rs=0x7FFFFFFF, Rt=1, RegDst=1, Rd=5, WB=2'b10 → next edge AluResult=0x80000000, WriteReg=5, WB=2'b10, Zero=0.
- lw: ALUOp=00, ALUSrc=1, Rs=0x1000, imm=0xFFFFFFFC, RtAddr=8, M=2'b10, WB=2'b11 → AluResult=0x0FFC, WriteReg=8, M=2'b10, WB=2'b11.
- beq: ALUOp=01, Rs=Rt=0x55 → Zero=1, AluResult=0.
- MULTU 0xFFFFFFFF×2, followed by MFHI then MFLO:
  - ex_stall high for exactly 33 cycles; EX_MEM_WB=0 throughout.
  - MFHI → 0x00000001.
  - MFLO → 0xFFFFFFFE.
- DIVU 100/0: LO=0xFFFFFFFF, HI=100.
- Reset mid-DIVU: rst_n=0 at iteration 10 → ex_stall=0 next cycle, HI=LO=0.
